// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RISC-V controller: state encoding,
// opcode constants, mux-select codes, ALU operation codes and the per-state
// control word that the FSM registers.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore control word; the *_strobe / branch / pc_force bits are later
  // qualified by mem_ready, zero and reset in the top level.
  typedef struct packed {
    logic       adrsrc;
    logic       fetch_strobe;
    logic       branch;
    logic       pc_force;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t state_controls(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch_strobe = 1'b1;
        c.alusrca      = SRCA_PC;
        c.alusrcb      = SRCB_FOUR;
        c.resultsrc    = RES_ALURESULT;
        c.aluop        = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrca = SRCA_OLDPC;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adrsrc    = 1'b1;
        c.resultsrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.resultsrc = RES_DATA;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc    = 1'b1;
        c.resultsrc = RES_ALUOUT;
        c.memwrite  = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_RS2;
        c.aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alusrca = SRCA_RS1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.resultsrc = RES_ALUOUT;
        c.regwrite  = 1'b1;
      end
      S_BEQ: begin
        c.alusrca   = SRCA_RS1;
        c.alusrcb   = SRCB_RS2;
        c.aluop     = ALUOP_SUB;
        c.resultsrc = RES_ALUOUT;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alusrca   = SRCA_OLDPC;
        c.alusrcb   = SRCB_FOUR;
        c.resultsrc = RES_ALUOUT;
        c.pc_force  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_format(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: fixed add/sub requests from the FSM, or a decode of
// funct3/funct7b5 for R- and I-type instructions.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] aluctrl
);

  // Only R-type (op5=1) with funct7b5 set turns funct3=000 into a subtract;
  // addi with a negative immediate must stay an add.
  always_comb begin
    aluctrl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: aluctrl = ALU_ADD;
      ALUOP_SUB: aluctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  aluctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluctrl = ALU_SLT;
          3'b110:  aluctrl = ALU_OR;
          3'b111:  aluctrl = ALU_AND;
          default: aluctrl = ALU_ADD;
        endcase
      end
      default: aluctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RISC-V subset (lw, sw, R/I ALU ops,
// beq, jal). The control word is registered alongside the state so outputs
// come straight from flops, except for the mem_ready/zero/reset qualifiers.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] aluctrl,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_next;
  ctrl_t  ctrl_q;
  logic   active;

  // Next-state selection from the current state, opcode and memory handshake.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // State and control-word registers; the control word is decoded from the
  // state being entered so it always matches the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_controls(S_FETCH);
    end else begin
      state_q <= state_next;
      ctrl_q  <= state_controls(state_next);
    end
  end

  assign active    = ~reset;
  assign adrsrc    = ctrl_q.adrsrc;
  assign resultsrc = ctrl_q.resultsrc;
  assign alusrca   = ctrl_q.alusrca;
  assign alusrcb   = ctrl_q.alusrcb;
  assign irwrite   = active & ctrl_q.fetch_strobe & mem_ready;
  assign pcwrite   = active & ((ctrl_q.fetch_strobe & mem_ready) |
                               (ctrl_q.branch & zero) | ctrl_q.pc_force);
  assign memwrite  = active & ctrl_q.memwrite;
  assign regwrite  = active & ctrl_q.regwrite;
  assign illegal   = active & (state_q == S_DECODE) & ~is_supported(op);
  assign immsrc    = imm_format(op);
  assign state     = state_q;

  alu_decoder u_alu_decoder (
    .aluop    (ctrl_q.aluop),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .op5      (op[5]),
    .aluctrl  (aluctrl)
  );

endmodule
